// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and sizing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_STOP   = 3'b011,
    ST_PARITY = 3'b100
  } uart_state_e;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        IDLE_LEVEL  = 1'b1;
  localparam logic        START_LEVEL = 1'b0;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_done marks the last clock of every serial bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned    CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits MSB first, optional parity, 1 or 2 stop bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       data_t,
  output logic       busy
);

  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 data_t_q, data_t_d;
  logic                 bit_done;
  logic                 last_stop;
  logic                 accept;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state_q == ST_IDLE) || accept),
    .bit_done (bit_done)
  );

  assign last_stop = (state_q == ST_STOP) && bit_done &&
                     (stop_cnt_q == 1'(STOP_BITS - 1));

  always_comb begin
    tx_ready = !rst && ((state_q == ST_IDLE) || last_stop);
  end

  assign accept = tx_valid && tx_ready;
  assign data_t = data_t_q;
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;

    unique case (state_q)
      ST_IDLE: ;
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d   = {shift_q[DATA_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) begin
          if (last_stop) begin
            stop_cnt_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Acceptance overrides the per-state update, covering both IDLE and the final stop cycle.
    if (accept) begin
      state_d    = ST_START;
      shift_d    = data_in;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
      parity_d   = (PARITY_ODD != 0) ? ~^data_in : ^data_in;
    end

    // The line is registered from the next state so each level appears with its state.
    unique case (state_d)
      ST_START:  data_t_d = START_LEVEL;
      ST_DATA:   data_t_d = shift_d[DATA_BITS-1];
      ST_PARITY: data_t_d = parity_d;
      default:   data_t_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      data_t_q   <= IDLE_LEVEL;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      data_t_q   <= data_t_d;
    end
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter; the transmit-side counterpart of the team's UART receiver. Accepts a byte over a valid/ready handshake and shifts out a frame on `data_t`: start bit, 8 data bits MSB first, optional parity bit, then 1 or 2 stop bits. The line idles high. With default parameters (one bit per clock, no parity, one stop bit) the frame is bit-compatible with the existing receiver for loopback.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 1: clock cycles each serial bit is held; legal range ≥ 1.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN=0`.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

**Ports**
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `data_in` in 8: byte to send; sampled only on acceptance.
- `tx_valid` in 1: `data_in` is valid.
- `tx_ready` out 1: the block can accept a byte this cycle.
- `data_t` out 1: serial line, registered, idle high.
- `busy` out 1: a frame is in progress (any state other than IDLE).

## Operation

- **States:** IDLE, START, DATA, PARITY, STOP. Encodings live in the shared package.
- **Acceptance:** a byte is accepted when `tx_valid && tx_ready` is high at a rising edge.
  - On acceptance, `data_in` is loaded into an 8-bit shift register and the parity bit is computed from that captured byte.
- **IDLE:** `data_t` = 1. On acceptance, go to START.
- **START:** `data_t` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:** drive shift-register bit 7 for `CLKS_PER_BIT` cycles, then shift left.
  - A 3-bit bit counter counts the 8 bits.
  - After bit 0 is sent, go to PARITY if `PARITY_EN=1`, otherwise to STOP.
- **PARITY:** drive `^byte` for even parity or `~^byte` for odd, for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP:** `data_t` = 1 for `STOP_BITS × CLKS_PER_BIT` cycles, then go to IDLE.
- **`tx_ready`:** combinational.
  - High in IDLE.
  - Also high in the final cycle of the last stop bit, which allows gapless back-to-back frames.
  - Low otherwise, and forced low while `rst` is high.
- **Acceptance in the final stop cycle:** go directly to START; the next cycle begins the new start bit.
- **`data_in` / `tx_valid` changes mid-frame:** ignored.
- **Reset values:** `data_t` = 1, `busy` = 0, state = IDLE, counters = 0, shift register = 0. `tx_ready` = 1 from the first cycle after `rst` deasserts.
- **Reset mid-frame:** the frame is aborted. `data_t` = 1 from the next edge. No stop bits or remaining bits are emitted, and the pending byte is discarded.
- **Baud counter:** width `max(1, $clog2(CLKS_PER_BIT))`, counts 0 to `CLKS_PER_BIT-1`. A bit ends when the counter equals `CLKS_PER_BIT-1`. The counter wraps to 0 at every bit boundary and on acceptance.

## Timing

- **Latency:** byte accepted at edge N → `data_t` falls at edge N+1.
- **Bit width:** every bit is exactly `CLKS_PER_BIT` cycles; no jitter.
- **Frame length:** `(1 + 8 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT` cycles. Defaults give 10 cycles.
- **`busy`:** rises at edge N+1. It falls at the edge after the last stop cycle, unless a new byte was accepted in that cycle, in which case it stays high.
- **Throughput:** gapless back-to-back frames at one frame per frame length when `tx_valid` is held high.
- **Simultaneous `rst` and `tx_valid`:** `rst` wins; nothing is accepted.

## Structure

- **Shared package `uart_pkg`:**
  - State encodings (IDLE=3'b000, START=3'b001, DATA=3'b010, STOP=3'b011, PARITY=3'b100).
  - Frame constants: data width 8, idle level 1, start level 0.
  - The receiver migrates to the same package.
- **Sub-module `uart_baud_gen`:** the bit-period counter.
  - Inputs: `clk`, `rst`, `clear`.
  - Output: `bit_done`, high in the last cycle of each bit.
  - Parameterised by `CLKS_PER_BIT`.
  - Reusable later by an oversampling receiver.

## Test plan

- **Reset:** assert `rst` for 3 cycles mid-frame, with `tx_valid` high → `data_t` = 1, `busy` = 0, `tx_ready` = 0 during reset. After release: `tx_ready` = 1, no bits emitted.
- **Single byte 0xA5, defaults:** `data_t` over edges N+1..N+10 = 0,1,0,1,0,0,1,0,1,1. `tx_ready` low for edges N+1..N+9.
- **Loopback:** transmitter `data_t` into the UART receiver, defaults, bytes 0x00, 0xFF, 0x3C, 0xA5 → each appears on the receiver's `data_out`.
- **Parity and stop bits:** `CLKS_PER_BIT=4`, `PARITY_EN=1`, `PARITY_ODD=1`, `STOP_BITS=2`, byte 0x07.
  - Each bit held for exactly 4 cycles.
  - Parity bit = 0 (three ones, odd parity).
  - Frame = 48 cycles.
- **Back-to-back:** `tx_valid` held high with 0x81 then 0x7E, defaults → 20 contiguous cycles, start bit of the second frame immediately after the first frame's stop bit. `busy` never drops.
- **Mid-frame input changes:** `data_in` changed and `tx_valid` toggled during DATA → the transmitted byte is unchanged, and no second acceptance occurs until `tx_ready`.
